// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for the boot loader.
// The loader takes the master side; the UART/memory environment takes the slave side.
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: count byte, big-endian words, XOR checksum.
// Keeps the CPU in reset until an image has been written and verified.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam int           IW       = $clog2(DEPTH_WORDS);
    localparam logic [8:0]   LP_DEPTH = 9'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_WRITE,
        S_CHECK
    } state_t;

    state_t        r_state;
    logic          r_rx_ready;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic          r_cpu_hold;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic [31:0]   r_word;
    logic [1:0]    r_byte;
    logic [IW-1:0] r_index;
    logic [IW:0]   r_count;
    logic [7:0]    r_csum;

    logic          w_accept;
    logic          w_count_bad;
    logic [31:0]   w_word_next;
    logic [7:0]    w_csum_next;
    logic [IW:0]   w_index_inc;
    logic [31:0]   w_addr;

    assign w_accept    = bus.rx_valid && r_rx_ready;
    assign w_count_bad = (bus.rx_data == 8'd0) ||
                         ({1'b0, bus.rx_data} > LP_DEPTH);
    assign w_word_next = {r_word[23:0], bus.rx_data};
    assign w_csum_next = r_csum ^ bus.rx_data;
    assign w_index_inc = {1'b0, r_index} + (IW+1)'(1);
    assign w_addr      = BASE_ADDR + (32'(r_index) << 2);

    assign bus.rx_ready  = r_rx_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign cpu_hold      = r_cpu_hold;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;

    // Load sequencer; rx_ready and busy are registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rx_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_cpu_hold  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_word      <= 32'd0;
            r_byte      <= 2'd0;
            r_index     <= '0;
            r_count     <= '0;
            r_csum      <= 8'd0;
        end else begin
            r_done   <= 1'b0;
            r_mem_we <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_COUNT;
                        r_error    <= 1'b0;
                        r_cpu_hold <= 1'b1;
                        r_csum     <= 8'd0;
                        r_index    <= '0;
                        r_byte     <= 2'd0;
                        r_rx_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (w_accept) begin
                        r_csum <= w_csum_next;
                        if (w_count_bad) begin
                            r_error    <= 1'b1;
                            r_done     <= 1'b1;
                            r_state    <= S_IDLE;
                            r_rx_ready <= 1'b0;
                            r_busy     <= 1'b0;
                        end else begin
                            r_count <= bus.rx_data[IW:0];
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_word <= w_word_next;
                        r_csum <= w_csum_next;
                        r_byte <= r_byte + 2'd1;
                        if (r_byte == 2'd3) begin
                            r_state     <= S_WRITE;
                            r_rx_ready  <= 1'b0;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= w_addr;
                            r_mem_wdata <= w_word_next;
                        end
                    end
                end
                S_WRITE: begin
                    // Index stays at N-1 after the last word so it never
                    // points past the image.
                    r_rx_ready <= 1'b1;
                    if (w_index_inc == r_count) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_index <= w_index_inc[IW-1:0];
                        r_state <= S_DATA;
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        r_done     <= 1'b1;
                        r_state    <= S_IDLE;
                        r_rx_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        if (bus.rx_data == r_csum) begin
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_rx_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0x0 and 0x100) share one stream;
// writes are scoreboarded against a byte-stream level model of the image format.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] rx_data;
    logic       rx_valid;

    logic hold_a, busy_a, done_a, err_a;
    logic hold_b, busy_b, done_b, err_b;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int done_a_n = 0;
    int done_b_n = 0;

    logic [63:0] wq_a[$];
    logic [63:0] wq_b[$];
    int          wc_a[$];
    logic [7:0]  stream[$];

    always #5 clk = ~clk;

    imem_loader_if ifa();
    imem_loader_if ifb();

    assign ifa.rx_data  = rx_data;
    assign ifa.rx_valid = rx_valid;
    assign ifb.rx_data  = rx_data;
    assign ifb.rx_valid = rx_valid;

    imem_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(64)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (ifa),
        .cpu_hold (hold_a),
        .busy     (busy_a),
        .done     (done_a),
        .error    (err_a)
    );

    imem_loader #(.BASE_ADDR(32'h0000_0100), .DEPTH_WORDS(64)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (ifb),
        .cpu_hold (hold_b),
        .busy     (busy_b),
        .done     (done_b),
        .error    (err_b)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (ifa.mem_we === 1'b1) begin
            wq_a.push_back({ifa.mem_addr, ifa.mem_wdata});
            wc_a.push_back(cyc);
            chk("rdy_in_write_a", ifa.rx_ready, 0);
        end
        if (ifb.mem_we === 1'b1) begin
            wq_b.push_back({ifb.mem_addr, ifb.mem_wdata});
            chk("rdy_in_write_b", ifb.rx_ready, 0);
        end
        if (done_a === 1'b1) done_a_n++;
        if (done_b === 1'b1) done_b_n++;
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (ifa.rx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            chk("rx_ready_timeout", 0, 1);
            rx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic build_random(input int n, input bit bad);
        logic [7:0] cs;
        logic [7:0] b;
        stream.delete();
        stream.push_back(8'(n));
        cs = 8'(n);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom_range(0, 255));
            stream.push_back(b);
            cs ^= b;
        end
        if (bad) cs ^= 8'($urandom_range(1, 255));
        stream.push_back(cs);
    endtask

    task automatic check_result(input int d0a, input int d0b, input bit tm);
        int         n;
        bit         bad_n;
        bit         e;
        logic [7:0] cs;
        logic [31:0] w;
        n = int'(stream[0]);
        bad_n = (n == 0) || (n > 64);
        e = 1'b1;
        if (!bad_n) begin
            cs = 8'd0;
            for (int i = 0; i <= 4 * n; i++) cs ^= stream[i];
            e = (stream[4 * n + 1] != cs);
        end
        chk("nwrites_a", wq_a.size(), bad_n ? 0 : n);
        chk("nwrites_b", wq_b.size(), bad_n ? 0 : n);
        if (!bad_n) begin
            for (int i = 0; i < n; i++) begin
                w = {stream[4*i+1], stream[4*i+2], stream[4*i+3], stream[4*i+4]};
                if (i < wq_a.size())
                    chk("write_a", wq_a[i], {32'(4 * i), w});
                if (i < wq_b.size())
                    chk("write_b", wq_b[i], {32'h100 + 32'(4 * i), w});
            end
            if (tm && n >= 2 && wc_a.size() >= 2)
                chk("word_cycles", wc_a[1] - wc_a[0], 5);
        end
        chk("error_a", err_a, e);
        chk("error_b", err_b, e);
        chk("hold_a", hold_a, e);
        chk("hold_b", hold_b, e);
        chk("busy_a", busy_a, 0);
        chk("done_pulses_a", done_a_n - d0a, 1);
        chk("done_pulses_b", done_b_n - d0b, 1);
    endtask

    task automatic run_load(input int gap, input int start_at, input bit tm);
        int d0a;
        int d0b;
        int t;
        wq_a.delete();
        wq_b.delete();
        wc_a.delete();
        d0a = done_a_n;
        d0b = done_b_n;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        foreach (stream[i]) begin
            if (i == start_at) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(stream[i], gap);
        end
        t = 0;
        while (done_a_n == d0a && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check_result(d0a, d0b, tm);
    endtask

    task automatic load_nominal();
        stream = '{8'h02, 8'h20, 8'h10, 8'h00, 8'h02,
                   8'h02, 8'h10, 8'h80, 8'h20, 8'h82};
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        chk("rst_hold", hold_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_ready", ifa.rx_ready, 0);
        chk("rst_addr", ifa.mem_addr, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        load_nominal();
        run_load(0, -1, 1'b1);

        load_nominal();
        stream[9] = 8'h83;
        run_load(0, -1, 1'b0);

        load_nominal();
        run_load(0, -1, 1'b1);

        stream = '{8'h00};
        run_load(0, -1, 1'b0);

        stream = '{8'h41};
        run_load(0, -1, 1'b0);

        build_random(64, 1'b0);
        run_load(0, -1, 1'b0);
        if (wq_a.size() == 64) chk("last_addr", wq_a[63][63:32], 32'hFC);
        else chk("last_addr_present", wq_a.size(), 64);

        load_nominal();
        run_load(3, 5, 1'b0);

        // Reset after the sixth data byte.
        load_nominal();
        wq_a.delete();
        wq_b.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) send_byte(stream[i], 0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_hold", hold_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_done", done_a, 0);
        chk("mid_rst_error", err_a, 0);
        chk("mid_rst_ready", ifa.rx_ready, 0);
        chk("mid_rst_we", ifa.mem_we, 0);
        chk("mid_rst_addr", ifa.mem_addr, 0);
        chk("mid_rst_wdata", ifa.mem_wdata, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_rst_nwrites_a", wq_a.size(), 1);
        chk("mid_rst_nwrites_b", wq_b.size(), 1);
        load_nominal();
        run_load(0, -1, 1'b1);

        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 7) == 0)
                stream = '{8'($urandom_range(65, 255))};
            else
                build_random($urandom_range(1, 8), $urandom_range(0, 3) == 0);
            run_load($urandom_range(0, 2), -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
